// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ctrl data memory: access size codes,
// controller state encoding and the store byte-enable mask.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int MAX_NB = 8;

    // Lane bits that must be zero for an access of the given size to be aligned.
    function automatic logic [2:0] lane_lsb_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SZ_BYTE: m = 3'b000;
            SZ_HALF: m = 3'b001;
            SZ_WORD: m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    function automatic logic [MAX_NB-1:0] byte_mask(input logic [1:0] size,
                                                    input logic [2:0] lane);
        logic [MAX_NB-1:0] m;
        case (size)
            SZ_BYTE: m = 8'h01;
            SZ_HALF: m = 8'h03;
            SZ_WORD: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << lane;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: shifts the addressed lanes of a raw memory word down to
// bit 0 and sign- or zero-extends them to the full data width.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [2:0]        i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic        [DATA_W-1:0] w_sh;
    logic        [DATA_W-1:0] w_zext;
    logic signed [DATA_W-1:0] w_sext;

    assign w_sh = i_word >> {i_lane, 3'b000};

    always_comb begin
        w_zext = '0;
        w_sext = '0;
        case (i_size)
            SZ_BYTE: begin
                w_zext = DATA_W'(w_sh[7:0]);
                w_sext = DATA_W'($signed(w_sh[7:0]));
            end
            SZ_HALF: begin
                w_zext = DATA_W'(w_sh[15:0]);
                w_sext = DATA_W'($signed(w_sh[15:0]));
            end
            SZ_WORD: begin
                w_zext = DATA_W'(w_sh[31:0]);
                w_sext = DATA_W'($signed(w_sh[31:0]));
            end
            default: begin
                w_zext = w_sh;
                w_sext = $signed(w_sh);
            end
        endcase
        o_data = i_unsigned ? w_zext : w_sext;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory: byte/half/word(/dword) loads and stores, 1-cycle registered
// response, hardware clear sweep after reset. Optional fault reporting via DMEM_FAULT_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              busy
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int HI = LB + IW;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [IW-1:0]     r_clr_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rsp_valid;
    logic              r_rsp_fault;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_ready;
    logic              w_busy;
    logic              w_acc;
    logic              w_fault;
    logic              w_unused;
    logic [1:0]        w_size;
    logic [2:0]        w_lane;
    logic [2:0]        w_lane_lsb;
    logic [2:0]        w_lane_al;
    logic [IW-1:0]     w_idx;
    logic [7:0]        w_bmask_all;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_load;

    // A dword request on a 32-bit memory degrades to a word access.
    assign w_size      = (DATA_W == 32 && req_size == SZ_DWORD) ? SZ_WORD : req_size;
    assign w_lane      = 3'(req_addr[LB-1:0]);
    assign w_lane_lsb  = lane_lsb_mask(w_size);
    assign w_lane_al   = w_lane & ~w_lane_lsb;
    assign w_idx       = req_addr[LB +: IW];
    assign w_bmask_all = byte_mask(w_size, w_lane_al);
    assign w_wdata_sh  = req_wdata << {w_lane_al, 3'b000};
    assign w_acc       = req_valid && w_ready;

`ifdef DMEM_FAULT_EN
    assign w_fault = (|(w_lane & w_lane_lsb)) || ((req_addr >> HI) != '0);
`else
    assign w_fault = 1'b0;
`endif

    // Address bits above the index field are deliberately ignored (wrap).
    assign w_unused = ^{req_addr, w_bmask_all};

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_busy = 1'b1;
                if (r_clr_cnt == IW'(DEPTH - 1)) w_state_nxt = ST_READY;
            end
            ST_READY: w_ready = 1'b1;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_clr_cnt <= r_clr_cnt + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (rst_n && w_acc && req_we && !w_fault) begin
            for (int b = 0; b < NB; b++) begin
                if (w_bmask_all[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    dmem_load_align #(
        .DATA_W     (DATA_W)
    ) u_load_align (
        .i_word     (r_mem[w_idx]),
        .i_lane     (w_lane_al),
        .i_size     (w_size),
        .i_unsigned (req_unsigned),
        .o_data     (w_load)
    );

    // Response stage: loads sample the array at the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_rsp_valid <= w_acc;
            if (w_acc) begin
                r_rsp_fault <= w_fault;
                r_rsp_rdata <= (req_we || w_fault) ? '0 : w_load;
            end
        end
    end

    assign req_ready = w_ready;
    assign busy      = w_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (DATA_W=32, DEPTH=128); expectations
// follow DMEM_FAULT_EN when the bench is compiled with that macro.
module tb_dmem_ctrl;

`ifdef DMEM_FAULT_EN
    localparam bit FLT = 1'b1;
`else
    localparam bit FLT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_W(32), .DEPTH(128), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .busy         (busy)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic v, output logic [31:0] rd, output logic f);
        @(negedge clk);
        drive(we, sz, uns, a, wd);
        @(negedge clk);
        v  = rsp_valid;
        rd = rsp_rdata;
        f  = rsp_fault;
        req_valid = 1'b0;
    endtask

    // Counts rising edges until busy drops, bounded; also counts stray responses.
    task automatic wait_init(output int cnt, output int nvld);
        cnt  = 0;
        nvld = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (rsp_valid === 1'b1) nvld++;
        end while (busy === 1'b1 && cnt < 400);
    endtask

    initial begin
        logic        v;
        logic        f;
        logic [31:0] rd;
        int          cnt;
        int          nvld;
        int          bad;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h8000_00F0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h10,  32'h0, 32'hFFFF_FFF0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h10,  32'h0, 32'h0000_00F0, 1'b0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0, 32'hFFFF_8000, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0, 32'h0000_8000, 1'b0};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0, 32'h8000_00F0, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h16,  32'h1234_BEEF, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0, 32'hBEEF_0000, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h17,  32'h0, 32'hFFFF_FFBE, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 32'h16,  32'h0, 32'h0000_00EF, 1'b0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h13,  32'h0, FLT ? 32'h0 : 32'h8000_00F0, FLT};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h15,  32'hDEAD_BEEF, 32'h0, FLT};
        vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0, FLT ? 32'hBEEF_0000 : 32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h1234_5678, 32'h0, FLT};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0, FLT ? 32'h0 : 32'h1234_5678, 1'b0};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h11,  32'h0, FLT ? 32'h0 : 32'h0000_00F0, FLT};
        vecs[16] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0, 32'h8000_00F0, 1'b0};
        vecs[17] = '{1'b0, 2'd0, 1'b1, 32'h203, 32'h0, FLT ? 32'h0 : 32'h0000_0012, FLT};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_vld",   rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_fault", rsp_fault, 0);

        // Clear sweep length, then every word reads back zero, streamed back-to-back
        rst_n = 1'b1;
        wait_init(cnt, nvld);
        chk("init_cycles", cnt, 128);
        chk("init_ready",  req_ready, 1);
        chk("init_no_vld", nvld, 0);
        bad = 0;
        for (int i = 0; i <= 128; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (rsp_valid !== 1'b1) bad++;
                if (rsp_rdata !== 32'h0) bad++;
            end
            if (i < 128) drive(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0);
            else req_valid = 1'b0;
        end
        chk("sweep_words_bad", bad, 0);
        @(negedge clk);
        chk("sweep_vld_drop", rsp_valid, 0);

        // Table of single transactions
        for (int i = 0; i < 18; i++) begin
            xact(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, v, rd, f);
            chk($sformatf("vec%0d_vld", i),   v,  1);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_fault", i), f,  vecs[i].exp_fault);
        end

        // Store then immediately load the same word: no hazard, other bytes kept
        xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, v, rd, f);
        chk("b2b_pre_vld", v, 1);
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB);
        @(negedge clk);
        chk("b2b_sb_vld",   rsp_valid, 1);
        chk("b2b_sb_rdata", rsp_rdata, 0);
        drive(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        chk("b2b_lw_vld",   rsp_valid, 1);
        chk("b2b_lw_rdata", rsp_rdata, 32'h1122_AB44);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_vld_drop", rsp_valid, 0);

        // Reset coinciding with a load: response dropped, sweep restarts
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstld_vld",   rsp_valid, 0);
        chk("rstld_busy",  busy, 1);
        chk("rstld_ready", req_ready, 0);
        req_valid = 1'b0;
        rst_n = 1'b1;

        // One-cycle reset in the middle of the sweep restarts the full count
        repeat (50) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cnt, nvld);
        chk("mid_init_cycles", cnt, 128);
        chk("mid_no_vld", nvld, 0);

        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, v, rd, f);
        chk("post_clr_vld",   v,  1);
        chk("post_clr_rdata", rd, 0);
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, v, rd, f);
        chk("post_clr_rdata20", rd, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
